sdram_pro_atref: RTL and testbench
==================================

// Module: sdram_pro_atref
// PURPOSE
//  Auto-refresh engine of the SDRAM controller; sits beside the write/read engines, directly upstream of the arbiter.
//  After init_end, times the refresh interval and raises atref_req. Once the arbiter grants atref_en, it drives
//  the PRECHARGE-all + N x AUTO_REFRESH sequence (cmd/bank/addr), then pulses atref_end to return the bus.
// PARAMETERS
//  REF_PERIOD_CYC  750  sys_clk cycles between refresh requests (7.5us @100MHz)
//  TRP_CYC         2    NOP cycles after PRECHARGE (tRP)
//  TRFC_CYC        7    NOP cycles after each AUTO_REFRESH (tRFC)
//  REF_NUM         2    AUTO_REFRESH commands per sequence (>=1)
// PORTS
//  sys_clk        in   1   clock
//  sys_rst_n      in   1   asynchronous, active-low reset
//  init_end       in   1   level; SDRAM init complete, enables interval timer
//  atref_en       in   1   level grant from arbiter (registered there; stays high 1 cycle past atref_end)
//  atref_req      out  1   refresh request to arbiter
//  atref_end      out  1   1-cycle pulse, sequence done
//  atref_cmd      out  4   {cs_n,ras_n,cas_n,we_n}
//  atref_bank     out  2   bank address
//  atref_addr     out  13  address bus
//  atref_overrun  out  1   1-cycle pulse: interval tick while a request was already pending
// BEHAVIOUR
//  Reset: atref_req=0, atref_end=0, atref_overrun=0, cmd=NOP 4'b0111, bank=2'b11, addr=13'h1FFF, FSM=IDLE, counters=0.
//  Interval timer: held at 0 while init_end=0; otherwise counts 0..REF_PERIOD_CYC-1 and wraps, free-running
//   (period is not restarted by grants). Tick = count==REF_PERIOD_CYC-1.
//  atref_req: set on tick; cleared on the first cycle atref_en is sampled high; set wins over clear only if
//   tick and grant coincide (req stays 1). Tick while req=1 -> req unchanged, atref_overrun pulses.
//  Start: FSM leaves IDLE only on a rising edge of atref_en (registered previous value) -> a late/held atref_en
//   never retriggers. Rising edge while not in IDLE is ignored.
//  FSM (one state register, outputs Moore-decoded from registered state):
//   IDLE  : cmd NOP. atref_en rise -> PCHG.
//   PCHG  : 1 cycle, cmd PRECHARGE 4'b0010, addr[10]=1 (all banks), bank=2'b11 -> TRP.
//   TRP   : TRP_CYC cycles NOP -> AREF.
//   AREF  : 1 cycle, cmd AUTO_REFRESH 4'b0001 -> TRFC.
//   TRFC  : TRFC_CYC cycles NOP; ref_cnt+1; ref_cnt<REF_NUM -> AREF, else -> END.
//   END   : 1 cycle NOP, atref_end=1 -> IDLE.
//  Outside PCHG: bank=2'b11, addr=13'h1FFF. Sequence length = 2+TRP_CYC+REF_NUM*(1+TRFC_CYC) = 20 cycles default.
//  PRECHARGE appears the cycle after atref_en is first sampled high.
//  Wait counter width = clog2(max(TRP_CYC,TRFC_CYC)+1); interval counter width = clog2(REF_PERIOD_CYC).
//  init_end falling (not expected) -> timer clears, pending req held, running sequence completes.
//  Reset mid-sequence: immediate return to reset values; no atref_end issued.
// STRUCTURE
//  Shared package/defines: SDRAM command encodings (NOP, PRECHARGE, AUTO_REFRESH, ACTIVE, READ, WRITE, MRS),
//   timing defaults (TRP, TRFC, refresh period), 13-bit addr / 2-bit bank widths.
//  No sub-module: interval timer, request latch and sequence FSM live in one file.
// TESTING
//  init_end=1 at cycle 0, atref_en=0 -> atref_req rises after 750 cycles; next tick at 1500 pulses atref_overrun, req stays 1.
//  req=1, atref_en held 1 for 21 cycles -> req clears on first sample; cmd: 0010, 2xNOP, (0001, 7xNOP)x2, END w/ atref_end=1; total 20 cycles.
//  atref_en stays high 1 cycle after atref_end -> FSM remains IDLE, cmd NOP, no second PRECHARGE.
//  Tick coincides with atref_en sample -> req remains 1 and next grant starts a new sequence after atref_en goes low/high.
//  sys_rst_n low during 2nd TRFC -> all outputs at reset values, no atref_end; after release with init_end=1, req at cycle 750.
//  init_end=0 for 2000 cycles -> atref_req never asserts, cmd constant NOP.

Source files
------------

// File: rtl/sdram_pro_atref_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n}, timing defaults,
// bus widths and the auto-refresh sequencer state type.
package sdram_pro_atref_pkg;

    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;

    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_READ         = 4'b0101;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_MRS          = 4'b0000;

    // 100 MHz sys_clk: 7.5 us refresh interval, tRP 20 ns, tRFC 70 ns
    localparam int REF_PERIOD_DEF = 750;
    localparam int TRP_DEF        = 2;
    localparam int TRFC_DEF       = 7;
    localparam int REF_NUM_DEF    = 2;

    localparam logic [BANK_W-1:0] BANK_IDLE = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_IDLE = 13'h1FFF;
    localparam logic [ADDR_W-1:0] ADDR_PALL = 13'h0400;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PCHG = 3'd1,
        S_TRP  = 3'd2,
        S_AREF = 3'd3,
        S_TRFC = 3'd4,
        S_END  = 3'd5
    } atref_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_pro_atref.sv
// Auto-refresh engine: free-running refresh interval timer, request latch towards the arbiter,
// and the PRECHARGE-all + N x AUTO_REFRESH command sequencer run once per grant.
module sdram_pro_atref
    import sdram_pro_atref_pkg::*;
#(
    parameter int REF_PERIOD_CYC = REF_PERIOD_DEF,
    parameter int TRP_CYC        = TRP_DEF,
    parameter int TRFC_CYC       = TRFC_DEF,
    parameter int REF_NUM        = REF_NUM_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        atref_en,
    output logic        atref_req,
    output logic        atref_end,
    output logic [3:0]  atref_cmd,
    output logic [1:0]  atref_bank,
    output logic [12:0] atref_addr,
    output logic        atref_overrun,
    output logic [2:0]  atref_state
);

    // Handshake: atref_req is a level request held until the arbiter's grant atref_en is
    // first seen high; the grant's rising edge starts exactly one sequence, and atref_end
    // pulses in the last sequence cycle to hand the bus back.

    localparam int PER_W  = $clog2(REF_PERIOD_CYC);
    localparam int WAIT_W = $clog2(max_int(TRP_CYC, TRFC_CYC) + 1);
    localparam int REF_W  = $clog2(REF_NUM + 1);

    logic [PER_W-1:0]  per_cnt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [REF_W-1:0]  ref_cnt, ref_nxt;
    logic [REF_W-1:0]  ref_inc;
    logic              en_d;
    logic              en_rise;
    logic              tick;
    atref_state_t      state, state_nxt;

    assign tick    = init_end && (per_cnt == PER_W'(REF_PERIOD_CYC - 1));
    assign en_rise = atref_en && !en_d;
    assign ref_inc = ref_cnt + REF_W'(1);

    // Timer keeps its own period: grants never restart it, only init_end does.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            per_cnt       <= '0;
            atref_req     <= 1'b0;
            atref_overrun <= 1'b0;
            en_d          <= 1'b0;
        end else begin
            en_d          <= atref_en;
            atref_overrun <= tick && atref_req;
            if (!init_end || tick)
                per_cnt <= '0;
            else
                per_cnt <= per_cnt + PER_W'(1);
            if (tick)
                atref_req <= 1'b1;
            else if (en_rise)
                atref_req <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            ref_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            ref_cnt  <= ref_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        ref_nxt   = ref_cnt;
        case (state)
            S_IDLE: begin
                wait_nxt = '0;
                ref_nxt  = '0;
                if (en_rise)
                    state_nxt = S_PCHG;
            end
            S_PCHG: state_nxt = S_TRP;
            S_TRP: begin
                if (wait_cnt == WAIT_W'(TRP_CYC - 1)) begin
                    wait_nxt  = '0;
                    state_nxt = S_AREF;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_AREF: state_nxt = S_TRFC;
            S_TRFC: begin
                if (wait_cnt == WAIT_W'(TRFC_CYC - 1)) begin
                    wait_nxt  = '0;
                    ref_nxt   = ref_inc;
                    state_nxt = (ref_inc < REF_W'(REF_NUM)) ? S_AREF : S_END;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_END: begin
                ref_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs decode straight from the state register, so reset drives them idle at once.
    always_comb begin
        atref_cmd  = CMD_NOP;
        atref_bank = BANK_IDLE;
        atref_addr = ADDR_IDLE;
        atref_end  = 1'b0;
        case (state)
            S_PCHG: begin
                atref_cmd  = CMD_PRECHARGE;
                atref_addr = ADDR_PALL;
            end
            S_AREF:  atref_cmd = CMD_AUTO_REFRESH;
            S_END:   atref_end = 1'b1;
            default: ;
        endcase
    end

    assign atref_state = state;

endmodule

// File: tb/tb_sdram_pro_atref.sv
// Directed bench for sdram_pro_atref: interval timing, overrun, refresh command sequence,
// grant-edge handling, reset mid-sequence and init_end gating.
module tb_sdram_pro_atref;
    import sdram_pro_atref_pkg::*;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        init_end;
    logic        atref_en;
    logic        atref_req;
    logic        atref_end;
    logic [3:0]  atref_cmd;
    logic [1:0]  atref_bank;
    logic [12:0] atref_addr;
    logic        atref_overrun;
    logic [2:0]  atref_state;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  bank;
        logic [12:0] addr;
        logic [12:0] addr_mask;
        logic        end_p;
        logic [2:0]  st;
    } vec_t;

    vec_t seq_tab[20];

    sdram_pro_atref dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .init_end      (init_end),
        .atref_en      (atref_en),
        .atref_req     (atref_req),
        .atref_end     (atref_end),
        .atref_cmd     (atref_cmd),
        .atref_bank    (atref_bank),
        .atref_addr    (atref_addr),
        .atref_overrun (atref_overrun),
        .atref_state   (atref_state)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // driver helpers
    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk(name, {atref_req, atref_overrun, atref_end, atref_cmd, atref_bank, atref_addr, atref_state},
                  {1'b0, 1'b0, 1'b0, 4'b0111, 2'b11, 13'h1FFF, 3'd0});
    endtask

    function automatic vec_t mk(input logic [3:0] cmd, input logic [12:0] addr, input logic [12:0] mask,
                                input logic end_p, input atref_state_t st);
        vec_t v;
        v.cmd = cmd; v.bank = 2'b11; v.addr = addr; v.addr_mask = mask; v.end_p = end_p; v.st = st;
        return v;
    endfunction

    task automatic build_table();
        seq_tab[0] = mk(4'b0010, 13'h0400, 13'h0400, 1'b0, S_PCHG);
        for (int i = 1; i <= 2; i++) seq_tab[i] = mk(4'b0111, 13'h1FFF, 13'h1FFF, 1'b0, S_TRP);
        for (int r = 0; r < 2; r++) begin
            seq_tab[3 + r*8] = mk(4'b0001, 13'h1FFF, 13'h1FFF, 1'b0, S_AREF);
            for (int i = 1; i <= 7; i++) seq_tab[3 + r*8 + i] = mk(4'b0111, 13'h1FFF, 13'h1FFF, 1'b0, S_TRFC);
        end
        seq_tab[19] = mk(4'b0111, 13'h1FFF, 13'h1FFF, 1'b1, S_END);
    endtask

    // one clock per table row, starting with the edge that samples the grant rise
    task automatic check_seq(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step(1);
            chk($sformatf("%s_seq%0d", tag, i),
                {atref_cmd, atref_bank, atref_addr & seq_tab[i].addr_mask, atref_end, atref_state},
                {seq_tab[i].cmd, seq_tab[i].bank, seq_tab[i].addr, seq_tab[i].end_p, seq_tab[i].st});
        end
    endtask

    task automatic check_first_request(input string tag);
        step(749);
        chk({tag, "_req_before_tick"}, atref_req, 1'b0);
        step(1);
        chk({tag, "_req_at_750"}, atref_req, 1'b1);
    endtask

    initial begin
        int bad;
        build_table();
        sys_rst_n = 1'b0;
        init_end  = 1'b1;
        atref_en  = 1'b0;
        step(3);
        chk_idle_outputs("reset_state");

        // interval timer: first request after 750 edges
        sys_rst_n = 1'b1;
        check_first_request("boot");

        // second tick while still pending
        step(749);
        chk("overrun_before", atref_overrun, 1'b0);
        step(1);
        chk("overrun_pulse", {atref_overrun, atref_req}, 2'b11);
        step(1);
        chk("overrun_cleared", {atref_overrun, atref_req}, 2'b01);

        // grant held 21 sampled cycles: one full sequence
        atref_en = 1'b1;
        check_seq("grant1", 0, 0);
        chk("req_cleared_on_grant", atref_req, 1'b0);
        check_seq("grant1", 1, 19);
        step(1);
        chk("held_grant_no_retrigger", {atref_cmd, atref_end, atref_state}, {4'b0111, 1'b0, 3'd0});
        atref_en = 1'b0;
        step(1);
        chk("idle_after_release", {atref_cmd, atref_end, atref_state, atref_req}, {4'b0111, 1'b0, 3'd0, 1'b0});

        // grant rise coincides with tick at edge 2250
        step(726);
        chk("req_low_before_coincide", atref_req, 1'b0);
        atref_en = 1'b1;
        check_seq("coincide", 0, 0);
        chk("coincide_req_kept", {atref_req, atref_overrun}, 2'b10);
        check_seq("coincide", 1, 19);
        step(1);
        atref_en = 1'b0;
        step(1);
        chk("coincide_pending_idle", {atref_req, atref_state}, {1'b1, 3'd0});
        atref_en = 1'b1;
        check_seq("regrant", 0, 0);
        chk("regrant_req_cleared", atref_req, 1'b0);
        check_seq("regrant", 1, 13);

        // reset during the second tRFC wait
        sys_rst_n = 1'b0;
        #1;
        chk_idle_outputs("reset_mid_seq");
        atref_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (atref_end !== 1'b0 || atref_state !== 3'd0) bad++;
        end
        chk("reset_no_end", bad, 0);
        sys_rst_n = 1'b1;
        check_first_request("post_reset");

        // init_end low: timer held, no request, bus idle
        sys_rst_n = 1'b0;
        init_end  = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (atref_req !== 1'b0 || atref_overrun !== 1'b0 || atref_cmd !== 4'b0111) bad++;
        end
        chk("no_init_no_req", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
